// File: rtl/audio_bridge_pkg.sv
// Shared constants and types for audio_stream_bridge: register map, STATUS/CONTROL
// bit positions and the layout of the DATA read word.
package audio_bridge_pkg;

   localparam logic [1:0] REG_DATA    = 2'd0;
   localparam logic [1:0] REG_STATUS  = 2'd1;
   localparam logic [1:0] REG_CONTROL = 2'd2;
   localparam logic [1:0] REG_INFO    = 2'd3;

   localparam int ST_EMPTY = 16;
   localparam int ST_FULL  = 17;
   localparam int ST_OVF   = 18;
   localparam int ST_IRQ   = 19;

   localparam int CTL_WM_IE   = 0;
   localparam int CTL_OVF_IE  = 1;
   localparam int CTL_FLUSH   = 2;
   localparam int CTL_OVF_CLR = 3;
   localparam int CTL_THR_LSB = 16;

   typedef struct packed {
      logic        valid;
      logic [2:0]  rsvd;
      logic [3:0]  channel;
      logic [23:0] sample;
   } data_word_t;

   function automatic int ch_width(int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

endpackage

// File: rtl/audio_stream_bridge_if.sv
// Bus-slave and sample-stream signals of audio_stream_bridge; "slave" is the bridge
// side, "master" the HPS/producer side.
interface audio_stream_bridge_if #(
   parameter int DATA_SIZE = 24,
   parameter int CH_W      = 1
);
   logic                 chipselect;
   logic [1:0]           address;
   logic                 read;
   logic                 write;
   logic [31:0]          write_data;
   logic [31:0]          read_data;
   logic                 source_valid;
   logic [DATA_SIZE-1:0] source_data;
   logic [CH_W-1:0]      source_channel;
   logic                 source_ready;
   logic                 irq;

   modport slave (
      input  chipselect, address, read, write, write_data,
      input  source_valid, source_data, source_channel,
      output read_data, source_ready, irq
   );

   modport master (
      output chipselect, address, read, write, write_data,
      output source_valid, source_data, source_channel,
      input  read_data, source_ready, irq
   );
endinterface

// File: rtl/audio_sample_fifo.sv
// Synchronous FIFO with flush; head is visible combinationally so a pop can capture it
// on the same edge that advances the read pointer. A pop at full frees the slot for a push.
module audio_sample_fifo #(
   parameter int WIDTH      = 25,
   parameter int DEPTH      = 64,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic                  pop,
   input  logic                  flush,
   input  logic [WIDTH-1:0]      push_data,
   output logic [WIDTH-1:0]      head,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  full,
   output logic                  empty
);
   localparam int CW = ADDR_WIDTH + 1;

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic                  do_push;
   logic                  do_pop;

   assign empty   = (count == '0);
   assign full    = count[ADDR_WIDTH];
   assign do_pop  = pop && !empty;
   assign do_push = push && !flush && (!full || do_pop);
   assign head    = mem[rd_ptr];

   // NOTE: sample storage has no reset; its contents are meaningless until written,
   // and leaving it out keeps the array mappable onto RAM.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
         if (do_pop)  rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end
endmodule

// File: rtl/audio_stream_bridge.sv
// Channel-tagged audio sample FIFO exposed as a 4-register bus slave with overflow,
// flush and info registers. Define AUDIO_BRIDGE_IRQ_EN to include watermark/overflow irq.
module audio_stream_bridge
   import audio_bridge_pkg::*;
#(
   parameter int DATA_SIZE  = 24,
   parameter int NUM_CH     = 2,
   parameter int DEPTH      = 64,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input logic                   clk,
   input logic                   reset,
   audio_stream_bridge_if.slave  bus
);
   localparam int          CH_W      = ch_width(NUM_CH);
   localparam logic [31:0] INFO_WORD = {16'(DEPTH), 8'(NUM_CH), 8'(DATA_SIZE)};

   logic                        wr_en, rd_en, pop_req, flush, ovf_clr;
   logic                        ovf, irq_q, full, empty;
   logic [ADDR_WIDTH:0]         count;
   logic [CH_W+DATA_SIZE-1:0]   head;
   logic [CH_W-1:0]             head_ch;
   logic signed [DATA_SIZE-1:0] head_sample;
   logic [31:0]                 ctrl_word, status_word, rdata_q;
   data_word_t                  data_word;
   logic                        unused_wdata;

   assign wr_en   = bus.chipselect && bus.write;
   assign rd_en   = bus.chipselect && bus.read;
   assign pop_req = rd_en && (bus.address == REG_DATA);
   assign flush   = wr_en && (bus.address == REG_CONTROL) && bus.write_data[CTL_FLUSH];
   assign ovf_clr = wr_en && (bus.address == REG_CONTROL) && bus.write_data[CTL_OVF_CLR];

   assign bus.source_ready = reset && !full;

   audio_sample_fifo #(
      .WIDTH(CH_W + DATA_SIZE), .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)
   ) u_fifo (
      .clk(clk), .reset(reset),
      .push(bus.source_valid), .pop(pop_req), .flush(flush),
      .push_data({bus.source_channel, bus.source_data}),
      .head(head), .count(count), .full(full), .empty(empty)
   );

   assign {head_ch, head_sample} = head;

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      data_word = '0;
      if (!empty) begin
         data_word.valid   = 1'b1;
         data_word.channel = 4'(head_ch);
         data_word.sample  = 24'(head_sample);
      end
   end

   // A dropped push only counts when the same-cycle pop did not free a slot.
   always_ff @(posedge clk) begin
      if (!reset)                                       ovf <= 1'b0;
      else if (bus.source_valid && full && !pop_req)    ovf <= 1'b1;
      else if (flush || ovf_clr)                        ovf <= 1'b0;
   end

`ifdef AUDIO_BRIDGE_IRQ_EN
   logic        wm_ie, ovf_ie, wm_hit;
   logic [15:0] threshold, thr_eff;

   assign thr_eff   = (threshold == '0) ? 16'd1 : threshold;
   assign wm_hit    = 32'(count) >= 32'(thr_eff);
   assign ctrl_word = {threshold, 14'b0, ovf_ie, wm_ie};

   always_ff @(posedge clk) begin
      if (!reset) begin
         wm_ie     <= 1'b0;
         ovf_ie    <= 1'b0;
         threshold <= '0;
         irq_q     <= 1'b0;
      end else begin
         if (wr_en && bus.address == REG_CONTROL) begin
            wm_ie     <= bus.write_data[CTL_WM_IE];
            ovf_ie    <= bus.write_data[CTL_OVF_IE];
            threshold <= bus.write_data[CTL_THR_LSB +: 16];
         end
         irq_q <= (wm_ie && wm_hit) || (ovf_ie && ovf);
      end
   end

   assign unused_wdata = ^bus.write_data[15:4];
`else
   assign irq_q        = 1'b0;
   assign ctrl_word    = '0;
   assign unused_wdata = ^{bus.write_data[31:4], bus.write_data[1:0]};
`endif

   assign bus.irq = irq_q;

   always_comb begin
      status_word          = '0;
      status_word[15:0]    = 16'(count);
      status_word[ST_EMPTY] = empty;
      status_word[ST_FULL]  = full;
      status_word[ST_OVF]   = ovf;
      status_word[ST_IRQ]   = irq_q;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         rdata_q <= '0;
      end else if (rd_en) begin
         case (bus.address)
            REG_DATA:    rdata_q <= data_word;
            REG_STATUS:  rdata_q <= status_word;
            REG_CONTROL: rdata_q <= ctrl_word;
            default:     rdata_q <= INFO_WORD;
         endcase
      end
   end

   assign bus.read_data = rdata_q;
endmodule

// File: tb/tb_audio_stream_bridge.sv
// Self-checking bench for audio_stream_bridge: directed scenarios then random traffic,
// compared against a queue-based model of the FIFO and register map.
module tb_audio_stream_bridge;
   import audio_bridge_pkg::*;

   localparam int DATA_SIZE = 24;
   localparam int NUM_CH    = 2;
   localparam int DEPTH     = 64;
   localparam int CH_W      = ch_width(NUM_CH);
   localparam int EW        = CH_W + DATA_SIZE;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #10 clk = ~clk;

   audio_stream_bridge_if #(.DATA_SIZE(DATA_SIZE), .CH_W(CH_W)) bus ();

   audio_stream_bridge #(
      .DATA_SIZE(DATA_SIZE), .NUM_CH(NUM_CH), .DEPTH(DEPTH)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   bit [EW-1:0] q[$];
   bit          m_ovf, m_wm_ie, m_ovf_ie, m_irq;
   bit [15:0]   m_thr;
   bit [31:0]   m_rdata;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   function automatic bit [31:0] data_word(input bit [EW-1:0] e);
      bit signed [DATA_SIZE-1:0] s;
      s = e[DATA_SIZE-1:0];
      return {1'b1, 3'b000, 4'(e >> DATA_SIZE), 24'(s)};
   endfunction

   function automatic bit [31:0] reg_value(input bit [1:0] a);
      bit full, empty;
      full  = (q.size() == DEPTH);
      empty = (q.size() == 0);
      case (a)
         2'd0:    return empty ? 32'd0 : data_word(q[0]);
         2'd1:    return {12'b0, m_irq, m_ovf, full, empty, 16'(q.size())};
         2'd2:    return {m_thr, 14'b0, m_ovf_ie, m_wm_ie};
         default: return {16'(DEPTH), 8'(NUM_CH), 8'(DATA_SIZE)};
      endcase
   endfunction

   // Advance the model by one clock edge using the inputs the DUT sampled there.
   task automatic model(input bit rst_n, input bit v, input bit [EW-1:0] entry,
                        input bit cs, input bit rd, input bit wr,
                        input bit [1:0] a, input bit [31:0] wd);
      bit full, pop, flush, clr, wr_ctl, irq_next;
      bit [15:0] thr;
      if (!rst_n) begin
         q.delete();
         {m_ovf, m_wm_ie, m_ovf_ie, m_irq} = '0;
         m_thr   = '0;
         m_rdata = '0;
         return;
      end
      full   = (q.size() == DEPTH);
      pop    = cs && rd && a == 2'd0 && q.size() != 0;
      wr_ctl = cs && wr && a == 2'd2;
      flush  = wr_ctl && wd[2];
      clr    = wr_ctl && wd[3];
      thr    = (m_thr == 0) ? 16'd1 : m_thr;
      irq_next = (m_wm_ie && q.size() >= int'(thr)) || (m_ovf_ie && m_ovf);
      if (cs && rd) m_rdata = reg_value(a);
      if (v && full && !pop)   m_ovf = 1'b1;
      else if (flush || clr)   m_ovf = 1'b0;
      if (pop) void'(q.pop_front());
      if (flush) q.delete();
      else if (v && q.size() < DEPTH) q.push_back(entry);
`ifdef AUDIO_BRIDGE_IRQ_EN
      if (wr_ctl) begin
         m_wm_ie  = wd[0];
         m_ovf_ie = wd[1];
         m_thr    = wd[31:16];
      end
      m_irq = irq_next;
`else
      m_irq = 1'b0 & irq_next;
`endif
   endtask

   task automatic step(input bit rst_n, input bit v, input bit [CH_W-1:0] ch,
                       input bit [DATA_SIZE-1:0] d, input bit cs, input bit rd,
                       input bit wr, input bit [1:0] a, input bit [31:0] wd);
      reset              = rst_n;
      bus.source_valid   = v;
      bus.source_channel = ch;
      bus.source_data    = d;
      bus.chipselect     = cs;
      bus.read           = rd;
      bus.write          = wr;
      bus.address        = a;
      bus.write_data     = wd;
      @(posedge clk);
      model(rst_n, v, {ch, d}, cs, rd, wr, a, wd);
      #1;
      check("read_data", bus.read_data, m_rdata);
      check("source_ready", bus.source_ready, 32'(rst_n && q.size() < DEPTH));
      check("irq", bus.irq, 32'(m_irq));
   endtask

   task automatic idle();
      step(1, 0, '0, '0, 0, 0, 0, 2'd0, 32'd0);
   endtask

   task automatic push(input bit [CH_W-1:0] ch, input bit [DATA_SIZE-1:0] d);
      step(1, 1, ch, d, 0, 0, 0, 2'd0, 32'd0);
   endtask

   task automatic rd_reg(input bit [1:0] a);
      step(1, 0, '0, '0, 1, 1, 0, a, 32'd0);
   endtask

   task automatic wr_reg(input bit [1:0] a, input bit [31:0] wd);
      step(1, 0, '0, '0, 1, 0, 1, a, wd);
   endtask

   initial begin
      // Reset with activity on the inputs; nothing may be captured.
      repeat (3) step(0, 1, 1'b1, 24'h123456, 1, 1, 0, 2'd0, 32'd0);
      check("ready_in_reset", bus.source_ready, 32'd0);
      idle();
      rd_reg(REG_INFO);
      check("info", bus.read_data, 32'h0040_0218);
      rd_reg(REG_STATUS);
      check("status_reset", bus.read_data, 32'h0001_0000);
      check("ready_after_reset", bus.source_ready, 32'd1);

      push(1'b1, 24'h80_0001);
      rd_reg(REG_DATA);
      check("data_ch1", bus.read_data, 32'h8180_0001);
      rd_reg(REG_DATA);
      check("data_empty", bus.read_data, 32'h0000_0000);

      for (int i = 0; i < DEPTH; i++) push(CH_W'((i + 1) % 2), 24'h40_0000 + 24'(i));
      check("ready_full", bus.source_ready, 32'd0);
      push(1'b0, 24'h12_3456);
      rd_reg(REG_STATUS);
      check("status_ovf", bus.read_data, 32'h0006_0040);
      wr_reg(REG_CONTROL, 32'h8);
      rd_reg(REG_STATUS);
      check("status_ovf_clr", bus.read_data, 32'h0002_0040);

      step(1, 1, 1'b0, 24'hAB_CDEF, 1, 1, 0, REG_DATA, 32'd0);
      check("pop_at_full", bus.read_data, 32'h8140_0000);
      rd_reg(REG_STATUS);
      check("status_pushpop_full", bus.read_data, 32'h0002_0040);

      wr_reg(REG_CONTROL, 32'h4);
      wr_reg(REG_CONTROL, 32'h0008_0001);
      for (int i = 0; i < 7; i++) push(CH_W'(i % 2), 24'(i * 5));
      idle();
      check("irq_below_wm", bus.irq, 32'd0);
      push(1'b1, 24'hFF_FFFF);
      idle();
`ifdef AUDIO_BRIDGE_IRQ_EN
      check("irq_at_wm", bus.irq, 32'd1);
`else
      check("irq_tied_low", bus.irq, 32'd0);
`endif
      rd_reg(REG_DATA);
      idle();
      check("irq_after_pop", bus.irq, 32'd0);

      for (int i = 0; i < 3; i++) push(1'b0, 24'(i));
      step(1, 1, 1'b1, 24'h55_5555, 1, 0, 1, REG_CONTROL, 32'h4);
      idle();
      rd_reg(REG_STATUS);
      check("status_flush", bus.read_data, 32'h0001_0000);
      rd_reg(REG_DATA);
      check("data_after_flush", bus.read_data, 32'h0000_0000);

      // Random traffic; pop pressure varies by phase so the FIFO visits both ends.
      for (int ph = 0; ph < 30; ph++) begin
         int pop_pct;
         pop_pct = (ph % 3 == 0) ? 10 : (ph % 3 == 1) ? 70 : 40;
         for (int c = 0; c < 100; c++) begin
            bit v, cs, rd, wr;
            bit [1:0]  a;
            bit [31:0] wd;
            v  = $urandom_range(0, 99) < 55;
            rd = 0; wr = 0; cs = 0; a = 2'd0; wd = $urandom;
            if ($urandom_range(0, 99) < pop_pct) begin
               cs = 1; rd = 1;
               a  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : REG_DATA;
            end else if ($urandom_range(0, 99) < 6) begin
               cs = 1; wr = 1;
               a  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : REG_CONTROL;
               wd[31:16] = 16'($urandom_range(0, 70));
               wd[2]     = ($urandom_range(0, 7) == 0);
               wd[3]     = ($urandom_range(0, 3) == 0);
               if (wd[2]) v = 0;
            end
            if ($urandom_range(0, 499) == 0) step(0, v, '0, '0, 0, 0, 0, 2'd0, 32'd0);
            else step(1, v, CH_W'($urandom), DATA_SIZE'($urandom), cs, rd, wr, a, wd);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
